dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-ported 8-word DataMemory.
- Port 0 is the CPU datapath load/store path; port 1 is a secondary master (debug/DMA loader).
- Serialises accesses, drives DataMemory's Address/DWriteData/MemRead/MemWrite, and returns read data with a valid pulse.

Parameters:
- DATA_W, 32, data and address bus width (matches DataMemory data_bus_size).
- DEPTH, 8, number of memory words; used only by the optional bounds check.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- r0_req  in  1  port 0 access request; held with fields stable until the completion edge.
- r0_we  in  1  1 = write, 0 = read.
- r0_addr  in  DATA_W  word address.
- r0_wdata  in  DATA_W  write data.
- r0_gnt  out  1  grant; the access completes on the edge where r0_req && r0_gnt.
- r0_rdata  out  DATA_W  read data, valid when r0_rvalid.
- r0_rvalid  out  1  one-cycle pulse after a completed read.
- r0_err  out  1  bounds error pulse (optional feature; tied 0 otherwise).
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rdata, r1_rvalid, r1_err: identical set for port 1.
- mem_addr  out  DATA_W  to DataMemory Address.
- mem_wdata  out  DATA_W  to DataMemory DWriteData.
- mem_read  out  1  to MemRead.
- mem_write  out  1  to MemWrite.
- mem_rdata  in  DATA_W  from DReadData (combinational read).

Behaviour:
- Reset (reset==0, async): state IDLE, rr pointer = port 0, all gnt/rvalid/err = 0, rdata = 0, mem_addr = mem_wdata = 0, mem_read = mem_write = 0.
- FSM has two states, IDLE and SERVE.
- IDLE: on a rising edge with any req, pick the winner, latch its we/addr/wdata, set its gnt, and go to SERVE. With no req, stay in IDLE.
- SERVE (exactly one cycle per access):
  - mem_addr and mem_wdata come from the latch; mem_write = latched we; mem_read = !latched we.
  - The winner's gnt is high.
- Completion edge (end of SERVE):
  - DataMemory commits the write.
  - For a read, rdata <= mem_rdata and rvalid <= 1 for exactly one cycle; a write leaves rdata unchanged.
  - gnt drops. The rr pointer moves to the other port.
  - The other port's req is sampled at this edge: if high, go directly to SERVE for it (back-to-back, no bubble); otherwise go to IDLE.
  - The just-served port's req at this edge is ignored. A port re-requesting alone therefore sees one IDLE bubble (max 50% throughput per port; 100% memory utilisation when alternating).
- Tie in IDLE: the rr pointer wins. A lone requester always wins regardless of the pointer.
- A requester dropping req before its gnt arrives is illegal; the latched access still executes.
- Outside SERVE: mem_read = mem_write = 0; mem_addr/mem_wdata hold their last values.
- Reset mid-SERVE forces mem_write low asynchronously; the access is lost and no rvalid is produced.
- Addresses pass through unmodified. DataMemory wraps on addr[2:0].

Optional Feature:
- DMEM_ARB_BOUNDS_CHECK_EN defined:
  - A latched addr >= DEPTH still takes a SERVE cycle, but mem_read/mem_write stay 0.
  - rX_err pulses for one cycle after the completion edge; rvalid stays 0 and rdata is unchanged.
- Undefined: no check; rX_err is tied 0 and wrap-around is left to DataMemory.

Decomposition:
- Package dmem_arb_pkg holds:
  - the state encoding (IDLE, SERVE);
  - the port index constants PORT0 = 0, PORT1 = 1;
  - default DATA_W and DEPTH constants.
- Sub-module dmem_rr_pick: combinational two-way round-robin selector. Inputs: req[1:0], pointer, exclude mask. Outputs: winner index and valid.

Test Plan:
- Port 0 read only, addr 2, memory at reset values -> gnt for 1 cycle, r0_rdata = 0x00000055 with a 1-cycle r0_rvalid; port 1 is never granted.
- Port 1 write addr 7 data 0x12345678, then port 1 read addr 7 -> one IDLE bubble between the two grants, read returns 0x12345678.
- Both ports request from IDLE after reset -> port 0 granted first, then port 1 back-to-back. Repeating continuously gives strict alternation with mem_read or mem_write high every cycle.
- Port 0 reads addr 1 while port 1 writes addr 1 with 0xAAAA0000, both asserted together with pointer = 0 -> r0_rdata = 0x0000000A, and a later read returns 0xAAAA0000.
- Assert reset low during a SERVE write to addr 4 -> mem_write drops immediately, no rvalid, all outputs at reset values; after release, a read of addr 4 returns 0x00005555.
- With DMEM_ARB_BOUNDS_CHECK_EN, read addr 9 -> r0_err pulses for 1 cycle, r0_rvalid stays 0, mem_read never asserted.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: shared constants for the DataMemory arbiter.
// FSM state encoding, port indices, default bus width and memory depth.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 8;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SERVE = 1'b1;

  // Requester port indices
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // One-hot mask of a port index
  function automatic logic [1:0] port_onehot(input logic p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: both requester handshakes plus the DataMemory side.
// Handshake: a requester raises rX_req with rX_we/rX_addr/rX_wdata stable and
// holds them until the rising edge where rX_req && rX_gnt, which completes the
// access; a completed read returns rX_rdata with a one-cycle rX_rvalid pulse.
// The slave modport is the arbiter; master is the requesters plus memory.
interface dmem_arbiter_if #(
  parameter int DATA_W = 32
) ();
  logic              r0_req;
  logic              r0_we;
  logic [DATA_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata;
  logic              r0_gnt;
  logic [DATA_W-1:0] r0_rdata;
  logic              r0_rvalid;
  logic              r0_err;

  logic              r1_req;
  logic              r1_we;
  logic [DATA_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r1_gnt;
  logic [DATA_W-1:0] r1_rdata;
  logic              r1_rvalid;
  logic              r1_err;

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic [0:0]        dbg_state;

  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata,
    output r0_gnt, r0_rdata, r0_rvalid, r0_err,
    input  r1_req, r1_we, r1_addr, r1_wdata,
    output r1_gnt, r1_rdata, r1_rvalid, r1_err,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata,
    output dbg_state
  );

  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata,
    input  r0_gnt, r0_rdata, r0_rvalid, r0_err,
    output r1_req, r1_we, r1_addr, r1_wdata,
    input  r1_gnt, r1_rdata, r1_rvalid, r1_err,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata,
    input  dbg_state
  );
endinterface

// File: rtl/dmem_arbiter_rr_pick.sv
// dmem_rr_pick: combinational two-way round-robin selector.
// Excluded ports cannot win; a tie between eligible ports goes to the pointer.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  input  logic [1:0] excl_i,
  output logic       win_o,
  output logic       valid_o
);

  logic [1:0] elig;

  // Mask out excluded ports, then choose a lone requester or the pointer
  always_comb begin
    elig    = req_i & ~excl_i;
    valid_o = |elig;
    case (elig)
      2'b01:   win_o = PORT0;
      2'b10:   win_o = PORT1;
      default: win_o = ptr_i;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer in front of single-ported DataMemory.
// Each access takes exactly one SERVE cycle; at its completion edge the other
// port is served back-to-back if it is requesting.
// Optional: define DMEM_ARB_BOUNDS_CHECK_EN to turn accesses at addr >= DEPTH
// into a suppressed memory cycle with a one-cycle rX_err pulse.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic          clock,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic [0:0]        state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              win_q, win_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic       serve;
  logic       oob;
  logic       pick_ptr;
  logic [1:0] pick_excl;
  logic       pick_win;
  logic       pick_valid;

  assign serve = (state_q == ST_SERVE);
  assign oob   = CHECK_EN && (addr_q >= DATA_W'(DEPTH));

  // While serving, only the other port may follow; when idle, plain round-robin
  always_comb begin
    pick_ptr  = serve ? ~win_q : ptr_q;
    pick_excl = serve ? port_onehot(win_q) : 2'b00;
  end

  dmem_rr_pick u_pick (
    .req_i   ({bus.r1_req, bus.r0_req}),
    .ptr_i   (pick_ptr),
    .excl_i  (pick_excl),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  // Next-state: completion bookkeeping, then load the next winner if any
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rvalid_d = 2'b00;
    err_d    = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;

    if (serve) begin
      ptr_d = ~win_q;
      if (oob) begin
        err_d = port_onehot(win_q);
      end else if (!we_q) begin
        rvalid_d = port_onehot(win_q);
        if (win_q == PORT0) rdata0_d = bus.mem_rdata;
        else                rdata1_d = bus.mem_rdata;
      end
    end

    if (pick_valid) begin
      state_d = ST_SERVE;
      win_d   = pick_win;
      we_d    = pick_win ? bus.r1_we    : bus.r0_we;
      addr_d  = pick_win ? bus.r1_addr  : bus.r0_addr;
      wdata_d = pick_win ? bus.r1_wdata : bus.r0_wdata;
    end else begin
      state_d = ST_IDLE;
    end
  end

  // State registers; async reset abandons any in-flight access
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= PORT0;
      win_q    <= PORT0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Output decode; memory strobes only during SERVE, address/data hold otherwise
  always_comb begin
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_read  = serve && !we_q && !oob;
    bus.mem_write = serve &&  we_q && !oob;
    bus.r0_gnt    = serve && (win_q == PORT0);
    bus.r1_gnt    = serve && (win_q == PORT1);
    bus.r0_rvalid = rvalid_q[0];
    bus.r1_rvalid = rvalid_q[1];
    bus.r0_err    = err_q[0];
    bus.r1_err    = err_q[1];
    bus.r0_rdata  = rdata0_q;
    bus.r1_rdata  = rdata1_q;
    bus.dbg_state = state_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table plus a hand-written mid-access reset
// sequence. Contains a behavioural 8-word DataMemory with fixed initial contents.
module tb_dmem_arbiter;

  logic clock;
  logic reset;

  dmem_arbiter_if #(.DATA_W(32)) bus ();

  dmem_arbiter #(.DATA_W(32), .DEPTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- DataMemory model ----------------
  logic [31:0] mem [8];
  initial begin
    mem[0] = 32'h0000_0000;
    mem[1] = 32'h0000_000A;
    mem[2] = 32'h0000_0055;
    mem[3] = 32'h0000_005A;
    mem[4] = 32'h0000_5555;
    mem[5] = 32'h0000_5A5A;
    mem[6] = 32'h0000_55AA;
    mem[7] = 32'h0000_AAAA;
  end
  always @(posedge clock) if (bus.mem_write) mem[bus.mem_addr[2:0]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_addr[2:0]];

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst;
    bit          q0, w0;
    logic [31:0] a0, d0;
    bit          q1, w1;
    logic [31:0] a1, d1;
    logic [1:0]  e_gnt, e_rv, e_err;
    logic [31:0] e_rd0, e_rd1;
    bit          e_mr, e_mw;
    logic [31:0] e_ma;
  } vec_t;

  vec_t vecs[$];
  int   split;
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(bit rst, bit q0, bit w0, logic [31:0] a0, logic [31:0] d0,
                              bit q1, bit w1, logic [31:0] a1, logic [31:0] d1,
                              logic [1:0] g, logic [1:0] rv, logic [1:0] er,
                              logic [31:0] rd0, logic [31:0] rd1, bit mr, bit mw, logic [31:0] ma);
    vec_t v;
    v.rst = rst; v.q0 = q0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.q1 = q1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.e_gnt = g; v.e_rv = rv; v.e_err = er; v.e_rd0 = rd0; v.e_rd1 = rd1;
    v.e_mr = mr; v.e_mw = mw; v.e_ma = ma;
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit q0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                       input bit q1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
    bus.r0_req = q0; bus.r0_we = w0; bus.r0_addr = a0; bus.r0_wdata = d0;
    bus.r1_req = q1; bus.r1_we = w1; bus.r1_addr = a1; bus.r1_wdata = d1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " gnt"},    {30'd0, bus.r1_gnt, bus.r0_gnt}, 32'd0);
    chk({tag, " rvalid"}, {30'd0, bus.r1_rvalid, bus.r0_rvalid}, 32'd0);
    chk({tag, " err"},    {30'd0, bus.r1_err, bus.r0_err}, 32'd0);
    chk({tag, " rdata0"}, bus.r0_rdata, 32'd0);
    chk({tag, " rdata1"}, bus.r1_rdata, 32'd0);
    chk({tag, " maddr"},  bus.mem_addr, 32'd0);
    chk({tag, " mwdata"}, bus.mem_wdata, 32'd0);
    chk({tag, " mstrobe"}, {30'd0, bus.mem_write, bus.mem_read}, 32'd0);
    chk({tag, " state"},  {31'd0, bus.dbg_state}, 32'd0);
  endtask

  // Reset is entered and left on a falling edge
  task automatic do_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk_reset_state("reset");
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic apply(input int i);
    vec_t v;
    v = vecs[i];
    if (v.rst) do_reset();
    drive(v.q0, v.w0, v.a0, v.d0, v.q1, v.w1, v.a1, v.d1);
    @(posedge clock);
    @(negedge clock);
    chk($sformatf("v%0d gnt", i),    {30'd0, bus.r1_gnt, bus.r0_gnt}, {30'd0, v.e_gnt});
    chk($sformatf("v%0d rvalid", i), {30'd0, bus.r1_rvalid, bus.r0_rvalid}, {30'd0, v.e_rv});
    chk($sformatf("v%0d err", i),    {30'd0, bus.r1_err, bus.r0_err}, {30'd0, v.e_err});
    chk($sformatf("v%0d rdata0", i), bus.r0_rdata, v.e_rd0);
    chk($sformatf("v%0d rdata1", i), bus.r1_rdata, v.e_rd1);
    chk($sformatf("v%0d mem_read", i),  {31'd0, bus.mem_read},  {31'd0, v.e_mr});
    chk($sformatf("v%0d mem_write", i), {31'd0, bus.mem_write}, {31'd0, v.e_mw});
    chk($sformatf("v%0d mem_addr", i),  bus.mem_addr, v.e_ma);
  endtask

  // ---------------- test ----------------
  initial begin
    //                  rst q0 w0 a0 d0           q1 w1 a1 d1             gnt    rv     err    rd0           rd1           mr mw ma
    // port 0 lone read of addr 2; port 1 never granted
    vecs.push_back(mk(1, 1, 0, 2, 0,            0, 0, 0, 0,             2'b01, 2'b00, 2'b00, 32'h0,        32'h0,        1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 2, 0,            0, 0, 0, 0,             2'b00, 2'b01, 2'b00, 32'h55,       32'h0,        0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0,             2'b00, 2'b00, 2'b00, 32'h55,       32'h0,        0, 0, 2));
    // port 1 write then read of addr 7, with one idle bubble between grants
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 7, 32'h12345678,  2'b10, 2'b00, 2'b00, 32'h55,       32'h0,        0, 1, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 7, 32'h12345678,  2'b00, 2'b00, 2'b00, 32'h55,       32'h0,        0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 0, 7, 0,             2'b10, 2'b00, 2'b00, 32'h55,       32'h0,        1, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 0, 7, 0,             2'b00, 2'b10, 2'b00, 32'h55,       32'h12345678, 0, 0, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0,             2'b00, 2'b00, 2'b00, 32'h55,       32'h12345678, 0, 0, 7));
    // both requesting continuously after reset: strict alternation, port 0 first
    vecs.push_back(mk(1, 1, 0, 3, 0,            1, 0, 2, 0,             2'b01, 2'b00, 2'b00, 32'h0,        32'h0,        1, 0, 3));
    vecs.push_back(mk(0, 1, 0, 3, 0,            1, 0, 2, 0,             2'b10, 2'b01, 2'b00, 32'h5A,       32'h0,        1, 0, 2));
    vecs.push_back(mk(0, 1, 0, 3, 0,            1, 0, 2, 0,             2'b01, 2'b10, 2'b00, 32'h5A,       32'h55,       1, 0, 3));
    vecs.push_back(mk(0, 1, 0, 3, 0,            1, 0, 2, 0,             2'b10, 2'b01, 2'b00, 32'h5A,       32'h55,       1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0,             2'b00, 2'b10, 2'b00, 32'h5A,       32'h55,       0, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0,             2'b00, 2'b00, 2'b00, 32'h5A,       32'h55,       0, 0, 2));
    // simultaneous read (port 0) and write (port 1) of addr 1, pointer at port 0
    vecs.push_back(mk(1, 1, 0, 1, 0,            1, 1, 1, 32'hAAAA0000,  2'b01, 2'b00, 2'b00, 32'h0,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0,            1, 1, 1, 32'hAAAA0000,  2'b10, 2'b01, 2'b00, 32'hA,        32'h0,        0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,            1, 1, 1, 32'hAAAA0000,  2'b00, 2'b00, 2'b00, 32'hA,        32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0,            0, 0, 0, 0,             2'b01, 2'b00, 2'b00, 32'hA,        32'h0,        1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 1, 0,            0, 0, 0, 0,             2'b00, 2'b01, 2'b00, 32'hAAAA0000, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0,             2'b00, 2'b00, 2'b00, 32'hAAAA0000, 32'h0,        0, 0, 1));
    split = vecs.size();
    // after the aborted write: addr 4 still holds its original value
    vecs.push_back(mk(0, 1, 0, 4, 0,            0, 0, 0, 0,             2'b01, 2'b00, 2'b00, 32'h0,        32'h0,        1, 0, 4));
    vecs.push_back(mk(0, 1, 0, 4, 0,            0, 0, 0, 0,             2'b00, 2'b01, 2'b00, 32'h5555,     32'h0,        0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0,             2'b00, 2'b00, 2'b00, 32'h5555,     32'h0,        0, 0, 4));
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    // out-of-range read: error pulse, no memory strobe, no rvalid
    vecs.push_back(mk(0, 1, 0, 9, 0,            0, 0, 0, 0,             2'b01, 2'b00, 2'b00, 32'h5555,     32'h0,        0, 0, 9));
    vecs.push_back(mk(0, 1, 0, 9, 0,            0, 0, 0, 0,             2'b00, 2'b00, 2'b01, 32'h5555,     32'h0,        0, 0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0,             2'b00, 2'b00, 2'b00, 32'h5555,     32'h0,        0, 0, 9));
`else
    // no bounds check: addr 9 passes through and memory wraps to word 1
    vecs.push_back(mk(0, 1, 0, 9, 0,            0, 0, 0, 0,             2'b01, 2'b00, 2'b00, 32'h5555,     32'h0,        1, 0, 9));
    vecs.push_back(mk(0, 1, 0, 9, 0,            0, 0, 0, 0,             2'b00, 2'b01, 2'b00, 32'hAAAA0000, 32'h0,        0, 0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0, 0,             2'b00, 2'b00, 2'b00, 32'hAAAA0000, 32'h0,        0, 0, 9));
`endif

    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);

    for (int i = 0; i < split; i++) apply(i);

    // reset asserted in the middle of a SERVE write to addr 4
    drive(1, 1, 4, 32'hDEADBEEF, 0, 0, 0, 0);
    @(posedge clock);
    @(negedge clock);
    chk("midrst pre mem_write", {31'd0, bus.mem_write}, 32'd1);
    chk("midrst pre gnt0",      {31'd0, bus.r0_gnt},    32'd1);
    chk("midrst pre mem_addr",  bus.mem_addr,  32'd4);
    chk("midrst pre mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("midrst async");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    chk_reset_state("midrst held");
    reset = 1'b1;

    for (int i = split; i < vecs.size(); i++) apply(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
